// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end. It issues sequential requests to a synchronous
// instruction ROM and buffers the returned words in a small circular queue for
// the decode stage. A credit check stops the queue from overflowing: one slot is
// reserved for every request whose response has not yet arrived. A
// branch/jump redirect flushes the queue and restarts fetching at a new PC.
//
// Parameters
//   XLEN      PC / address width
//   DEPTH     queue entry count (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous, active-high reset
//   im_addr      instruction-memory address (fetch PC)
//   im_req       a request for im_addr is issued this cycle
//   im_r_data    instruction word, valid one cycle after the matching im_req
//   redirect     branch/jump taken: flush the queue and refetch
//   redirect_pc  target address, sampled while redirect=1
//   d_ready      decode accepts the head entry (0 = stall)
//   d_valid      head entry is valid (0 = bubble to decode)
//   d_pc         PC of the head entry
//   d_inst       instruction of the head entry
//   count        number of valid entries
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic [XLEN-1:0]              im_addr,
   output logic                         im_req,
   input  logic [31:0]                  im_r_data,
   input  logic                         redirect,
   input  logic [XLEN-1:0]              redirect_pc,
   input  logic                         d_ready,
   output logic                         d_valid,
   output logic [XLEN-1:0]              d_pc,
   output logic [31:0]                  d_inst,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   // DEPTH widened by one bit so it compares directly against count + inflight.
   localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP  = (XLEN)'(4);
   localparam logic [PW-1:0]   PTR_ONE  = (PW)'(1);
   localparam logic [CW-1:0]   CNT_ONE  = (CW)'(1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0] pc_q,       pc_d;        // next address to fetch
   logic [XLEN-1:0] req_pc_q,   req_pc_d;    // PC of the request now in flight
   logic            inflight_q, inflight_d;  // a response arrives this cycle
   logic [PW-1:0]   head_q,     head_d;
   logic [PW-1:0]   tail_q,     tail_d;
   logic [CW-1:0]   count_q,    count_d;

   // Entry storage is deliberately unreset: only count and the pointers decide
   // which entries hold live data.
   logic [XLEN-1:0] pc_mem_q   [DEPTH];
   logic [31:0]     inst_mem_q [DEPTH];

   // ---------------------------------------------------------------------------
   // Control decode
   // ---------------------------------------------------------------------------
   logic [CW:0] credit_s;   // entries held plus the slot reserved for the in-flight response
   logic        issue_s;
   logic        push_s;
   logic        pop_s;
   logic        valid_s;

   // Issue, push and pop qualifiers. Redirect and reset block all three; the
   // response returning in a redirect cycle belongs to the old path and is dropped.
   always_comb begin
      credit_s = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
      valid_s  = (count_q != {CW{1'b0}});
      issue_s  = !rst && !redirect && (credit_s < DEPTH_W);
      push_s   = !rst && !redirect && inflight_q;
      pop_s    = !rst && !redirect && valid_s && d_ready;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------

   // Fetch PC, in-flight tracking, queue pointers and occupancy.
   always_comb begin
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = 1'b0;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;

      if (redirect) begin
         // Flush: everything queued or in flight is from the wrong path.
         pc_d       = redirect_pc;
         inflight_d = 1'b0;
         head_d     = {PW{1'b0}};
         tail_d     = {PW{1'b0}};
         count_d    = {CW{1'b0}};
      end else begin
         if (issue_s) begin
            pc_d       = pc_q + PC_STEP;   // wraps modulo 2^XLEN
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
         end else begin
            pc_d       = pc_q;
            req_pc_d   = req_pc_q;
            inflight_d = 1'b0;
         end

         // Pointers wrap naturally because DEPTH is a power of two.
         if (push_s) begin
            tail_d = tail_q + PTR_ONE;
         end else begin
            tail_d = tail_q;
         end

         if (pop_s) begin
            head_d = head_q + PTR_ONE;
         end else begin
            head_d = head_q;
         end

         // The credit check guarantees push never happens with count = DEPTH.
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------

   // Control state with synchronous reset; reset wins over redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
         head_q     <= {PW{1'b0}};
         tail_q     <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Entry storage: write the returning word together with the PC it was fetched from.
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_q[tail_q]   <= req_pc_q;
         inst_mem_q[tail_q] <= im_r_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------

   // While reset is held the PC register may not yet be initialised, so the
   // address is forced to RESET_PC directly.
   always_comb begin
      if (rst) begin
         im_addr = RESET_PC;
      end else begin
         im_addr = pc_q;
      end
      im_req  = issue_s;
      d_valid = valid_s;
      d_pc    = pc_mem_q[head_q];
      d_inst  = inst_mem_q[head_q];
      count   = count_q;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue (XLEN=32, DEPTH=4, RESET_PC=0). The ROM model
// returns its own address as the instruction word one cycle after the address,
// so every expected d_pc/d_inst is a hand-computed address.
// Inputs change 1 time unit after the rising edge; outputs are checked a further
// time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] im_addr;
   logic        im_req;
   logic [31:0] im_r_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        d_ready;
   logic        d_valid;
   logic [31:0] d_pc;
   logic [31:0] d_inst;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   fetch_queue #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .im_addr     (im_addr),
      .im_req      (im_req),
      .im_r_data   (im_r_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .d_ready     (d_ready),
      .d_valid     (d_valid),
      .d_pc        (d_pc),
      .d_inst      (d_inst),
      .count       (count)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Synchronous ROM: word = address, one cycle of latency.
   always @(posedge clk) begin
      im_r_data <= im_addr;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed stimulus and checks.
   initial begin
      logic [31:0] exp_pc;
      int          pops;
      int          cyc;

      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      d_ready     = 1'b1;
      #1;
      chk("rst_im_req",  im_req,  64'd0);
      chk("rst_im_addr", im_addr, 64'h0);
      tick();
      tick();
      chk("rst_count",   count,   64'd0);
      chk("rst_d_valid", d_valid, 64'd0);

      // ---- streaming with d_ready=1: 2-cycle fill, then one per cycle ----
      rst = 1'b0;
      #1;
      chk("t1_c0_req",  im_req,  64'd1);
      chk("t1_c0_addr", im_addr, 64'h0);
      tick();
      chk("t1_c1_req",    im_req,  64'd1);
      chk("t1_c1_addr",   im_addr, 64'h4);
      chk("t1_c1_dvalid", d_valid, 64'd0);
      tick();
      chk("t1_c2_dvalid", d_valid, 64'd1);
      chk("t1_c2_dpc",    d_pc,    64'h0);
      chk("t1_c2_dinst",  d_inst,  64'h0);
      chk("t1_c2_addr",   im_addr, 64'h8);
      chk("t1_c2_count",  count,   64'd1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t1_stream_dvalid", d_valid, 64'd1);
         chk("t1_stream_dpc",    d_pc,    64'(4 * i));
         chk("t1_stream_dinst",  d_inst,  64'(4 * i));
         chk("t1_stream_count",  count,   64'd1);
      end

      // ---- stall from reset release: fill to 4, then drain without a gap ----
      rst     = 1'b1;
      d_ready = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("t2_c0_count",  count,   64'd0);
      chk("t2_c0_dvalid", d_valid, 64'd0);
      chk("t2_c0_addr",   im_addr, 64'h0);
      chk("t2_c0_req",    im_req,  64'd1);
      tick(); tick(); tick(); tick();
      chk("t2_c4_count", count,  64'd3);
      chk("t2_c4_req",   im_req, 64'd0);
      tick();
      chk("t2_c5_count", count,   64'd4);
      chk("t2_c5_req",   im_req,  64'd0);
      chk("t2_c5_dpc",   d_pc,    64'h0);
      chk("t2_c5_addr",  im_addr, 64'h10);
      tick();
      chk("t2_c6_count", count, 64'd4);
      chk("t2_c6_dpc",   d_pc,  64'h0);
      d_ready = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("t2_drain_dvalid", d_valid, 64'd1);
         chk("t2_drain_dpc",    d_pc,    64'(4 * i));
         tick();
      end

      // ---- redirect with 3 queued and 1 in flight ----
      rst     = 1'b1;
      d_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick(); tick(); tick(); tick();
      chk("t3_pre_count", count,  64'd3);
      chk("t3_pre_req",   im_req, 64'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      #1;
      chk("t3_redir_req", im_req, 64'd0);
      tick();
      redirect = 1'b0;
      #1;
      chk("t3_n1_count",  count,   64'd0);
      chk("t3_n1_dvalid", d_valid, 64'd0);
      chk("t3_n1_addr",   im_addr, 64'h100);
      chk("t3_n1_req",    im_req,  64'd1);
      tick();
      chk("t3_n2_count", count,   64'd0);
      chk("t3_n2_addr",  im_addr, 64'h104);
      tick();
      chk("t3_n3_count",  count,   64'd1);
      chk("t3_n3_dvalid", d_valid, 64'd1);
      chk("t3_n3_dpc",    d_pc,    64'h100);
      chk("t3_n3_dinst",  d_inst,  64'h100);

      // ---- back-to-back redirects: the second target wins ----
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect_pc = 32'h80;
      tick();
      redirect = 1'b0;
      d_ready  = 1'b1;
      #1;
      chk("t4_addr",  im_addr, 64'h80);
      chk("t4_count", count,   64'd0);
      tick();
      tick();
      chk("t4_dvalid", d_valid, 64'd1);
      chk("t4_dpc",    d_pc,    64'h80);
      chk("t4_dinst",  d_inst,  64'h80);

      // ---- alternating d_ready for 20 pops: pointers wrap, PCs stay sequential ----
      exp_pc = 32'h84;
      pops   = 0;
      cyc    = 0;
      while (pops < 20 && cyc < 200) begin
         tick();
         cyc++;
         d_ready = cyc[0];
         #1;
         if (d_valid && d_ready) begin
            chk("t5_wrap_dpc",   d_pc,   64'(exp_pc));
            chk("t5_wrap_dinst", d_inst, 64'(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
      end
      chk("t5_pop_count", 64'(pops), 64'd20);

      // ---- reset while full, with redirect also asserted ----
      d_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
      end
      chk("t6_full_count", count, 64'd4);
      rst         = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      #1;
      chk("t6_rst_req",  im_req,  64'd0);
      chk("t6_rst_addr", im_addr, 64'h0);
      tick();
      rst      = 1'b0;
      redirect = 1'b0;
      #1;
      chk("t6_post_count",  count,   64'd0);
      chk("t6_post_dvalid", d_valid, 64'd0);
      chk("t6_post_addr",   im_addr, 64'h0);
      chk("t6_post_req",    im_req,  64'd1);
      tick();
      tick();
      chk("t6_refill_dvalid", d_valid, 64'd1);
      chk("t6_refill_dpc",    d_pc,    64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the PC and address width.
REQ-002 Parameter DEPTH, default 4, SHALL set the queue entry count; a power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0, SHALL set the first fetch address after reset.
REQ-004 Port clk  input  1: single clock; all state on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port im_addr  output  XLEN: instruction-memory address, driven from the fetch PC register.
REQ-007 Port im_req  output  1: request issued this cycle for im_addr.
REQ-008 Port im_r_data  input  32: instruction word, valid exactly one cycle after the matching im_req (synchronous ROM).
REQ-009 Port redirect  input  1: branch/jump taken; flush and refetch.
REQ-010 Port redirect_pc  input  XLEN: target address, sampled when redirect=1.
REQ-011 Port d_ready  input  1: decode accepts the head entry; 0 = stall.
REQ-012 Port d_valid  output  1: head entry valid; 0 = bubble to decode.
REQ-013 Port d_pc  output  XLEN: PC of the head entry.
REQ-014 Port d_inst  output  32: instruction of the head entry.
REQ-015 Port count  output  clog2(DEPTH+1): number of valid entries.

Function
REQ-016 im_req SHALL be 1 iff rst=0, redirect=0 and (count + inflight) < DEPTH, where inflight is the 1-bit flag of a request issued last cycle.
REQ-017 On an issued request, fetch PC SHALL advance by 4 next cycle, wrapping modulo 2^XLEN; otherwise it SHALL hold.
REQ-018 inflight SHALL be set on the cycle after an issued request and cleared otherwise.
REQ-019 When inflight=1 and redirect=0, {PC of that request, im_r_data} SHALL be written at the tail, and the tail pointer SHALL advance modulo DEPTH.
REQ-020 Pop SHALL occur when d_valid=1 and d_ready=1; the head pointer SHALL advance modulo DEPTH.
REQ-021 d_valid SHALL equal (count != 0); d_pc and d_inst SHALL be read combinationally from the head entry and SHALL hold while d_ready=0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; push alone SHALL add 1; pop alone SHALL subtract 1.
REQ-023 The credit rule in REQ-016 SHALL make overflow impossible; a push never occurs when count = DEPTH.
REQ-024 With d_ready held at 1 and no redirect, throughput SHALL be one instruction per cycle after a 2-cycle fill latency from request to d_valid.
REQ-025 Redirect SHALL take priority over push, pop and issue: next cycle count=0, inflight=0, head=tail=0, and fetch PC=redirect_pc.
REQ-026 The im_r_data returning in the redirect cycle SHALL be discarded.
REQ-027 The first request after a redirect SHALL issue in the following cycle with im_addr=redirect_pc.
REQ-028 redirect asserted on consecutive cycles SHALL leave the last redirect_pc in effect.
REQ-029 Entry storage SHALL need no reset; validity SHALL be determined only by count and the pointers.

Reset
REQ-030 While rst=1: im_req=0 and im_addr=RESET_PC.
REQ-031 The cycle after rst is sampled high: count=0, inflight=0, d_valid=0, pointers=0, fetch PC=RESET_PC.
REQ-032 rst asserted mid-operation SHALL discard all entries and any in-flight response.
REQ-033 rst SHALL override redirect.

Verification
REQ-034 Reset then d_ready=1, ROM word=addr -> requests at 0,4,8,...; d_valid rises 2 cycles after rst falls; then one pop per cycle with d_pc=0,4,8 in order.
REQ-035 Stall: d_ready=0 from reset release -> count saturates at 4; im_req goes 0 with count+inflight=4; d_pc holds 0; raising d_ready drains 0,4,8,12 then 16 with no gap.
REQ-036 Redirect to 32'h100 with 3 entries queued and 1 in flight -> next cycle count=0, d_valid=0, im_addr=0x100; stale response not enqueued; the next d_pc is 0x100.
REQ-037 Wrap: DEPTH=4 with alternating d_ready for 20 pops -> pointers wrap and d_pc stays strictly sequential +4.
REQ-038 Redirect on two consecutive cycles (0x40, then 0x80) -> the first subsequent d_pc is 0x80.
REQ-039 rst pulse while full -> count=0 and im_addr=RESET_PC on the following cycle.
